// File: rtl/pri_arbiter.sv
// -----------------------------------------------------------------------------
// pri_arbiter
//   Registered priority encoder / arbiter with a valid/ready result port.
//   Picks one bit from the effective request vector (din & din_v) in one of
//   three runtime modes: LSB-first, MSB-first or round-robin. It also returns
//   the one-hot grant and the popcount of the request vector. The result
//   appears one cycle after it is loaded. A result that is valid but not yet
//   accepted is held stable under backpressure.
//
// Parameters
//   DWIDTH       number of request bits (>= 1)
//   IWIDTH       index width, derived
//   CWIDTH       count width, derived
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high
//   din          request bits
//   din_v        per-bit valid mask; effective request = din & din_v
//   enable       permits a new result to be loaded
//   mode         0 LSB-first, 1 MSB-first, 2 round-robin, 3 behaves as 0
//   dout         granted bit index
//   dout_onehot  one-hot grant, all zero when there is no request
//   dout_cnt     popcount of the effective request at load time
//   dout_v       result valid (at least one request bit was set)
//   dout_rdy     consumer accepts the result when dout_v && dout_rdy
// -----------------------------------------------------------------------------
module pri_arbiter #(
    parameter  int DWIDTH = 8,
    localparam int IWIDTH = (DWIDTH > 1) ? $clog2(DWIDTH) : 1,
    localparam int CWIDTH = $clog2(DWIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] din,
    input  logic [DWIDTH-1:0] din_v,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [IWIDTH-1:0] dout,
    output logic [DWIDTH-1:0] dout_onehot,
    output logic [CWIDTH-1:0] dout_cnt,
    output logic              dout_v,
    input  logic              dout_rdy
);

    localparam logic [1:0] MODE_LSB = 2'd0;
    localparam logic [1:0] MODE_MSB = 2'd1;
    localparam logic [1:0] MODE_RR  = 2'd2;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Lowest set index; scanning downward lets the lowest hit win.
    function automatic logic [IWIDTH-1:0] sel_lsb(input logic [DWIDTH-1:0] r);
        logic [IWIDTH-1:0] idx;
        idx = {IWIDTH{1'b0}};
        for (int i = DWIDTH - 1; i >= 0; i--) begin
            if (r[i]) begin
                idx = IWIDTH'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Highest set index; scanning upward lets the highest hit win.
    function automatic logic [IWIDTH-1:0] sel_msb(input logic [DWIDTH-1:0] r);
        logic [IWIDTH-1:0] idx;
        idx = {IWIDTH{1'b0}};
        for (int i = 0; i < DWIDTH; i++) begin
            if (r[i]) begin
                idx = IWIDTH'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // First set index at or above start, wrapping DWIDTH-1 -> 0.
    // The position is reduced by subtraction, so DWIDTH need not be a
    // power of two.
    function automatic logic [IWIDTH-1:0] sel_rr(input logic [DWIDTH-1:0] r,
                                                 input logic [IWIDTH-1:0] start);
        logic [IWIDTH-1:0] idx;
        logic              found;
        int                pos;
        idx   = {IWIDTH{1'b0}};
        found = 1'b0;
        for (int off = 0; off < DWIDTH; off++) begin
            pos = int'(start) + off;
            if (pos >= DWIDTH) begin
                pos = pos - DWIDTH;
            end else begin
                pos = pos;
            end
            if (!found && r[pos]) begin
                idx   = IWIDTH'(pos);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // Index + 1, modulo DWIDTH.
    function automatic logic [IWIDTH-1:0] wrap_inc(input logic [IWIDTH-1:0] idx);
        logic [IWIDTH-1:0] nxt;
        if (int'(idx) >= DWIDTH - 1) begin
            nxt = {IWIDTH{1'b0}};
        end else begin
            nxt = idx + IWIDTH'(1);
        end
        return nxt;
    endfunction

    // Number of set bits. DWIDTH always fits in CWIDTH, so no overflow.
    function automatic logic [CWIDTH-1:0] popcount(input logic [DWIDTH-1:0] r);
        logic [CWIDTH-1:0] cnt;
        cnt = {CWIDTH{1'b0}};
        for (int i = 0; i < DWIDTH; i++) begin
            cnt = cnt + CWIDTH'(r[i]);
        end
        return cnt;
    endfunction

    // One-hot decode of an index.
    function automatic logic [DWIDTH-1:0] to_onehot(input logic [IWIDTH-1:0] idx);
        logic [DWIDTH-1:0] oh;
        oh = {DWIDTH{1'b0}};
        for (int i = 0; i < DWIDTH; i++) begin
            if (int'(idx) == i) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IWIDTH-1:0] dout_r;
    logic [DWIDTH-1:0] onehot_r;
    logic [CWIDTH-1:0] cnt_r;
    logic              valid_r;
    logic [IWIDTH-1:0] ptr_r;
    logic [1:0]        mode_q_r;

    // ------------------------------------------------------------------
    // Combinational control and selection
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] req_s;
    logic              req_any_s;
    logic              accept_s;
    logic              load_s;
    logic              rr_adv_s;
    logic [IWIDTH-1:0] next_ptr_s;
    logic [IWIDTH-1:0] rr_start_s;
    logic [IWIDTH-1:0] sel_idx_s;

    assign req_s      = din & din_v;
    assign req_any_s  = |req_s;
    assign accept_s   = valid_r && dout_rdy;
    assign load_s     = enable && (!valid_r || dout_rdy);
    // Pointer advances only when a round-robin result is consumed; the
    // held result carries the mode it was produced under.
    assign rr_adv_s   = accept_s && (mode_q_r == MODE_RR);
    assign next_ptr_s = wrap_inc(dout_r);

    // Round-robin start: bypass the pointer register on the accepting
    // cycle so that back-to-back accepts rotate without repeating a grant.
    always_comb begin
        rr_start_s = ptr_r;
        if (rr_adv_s) begin
            rr_start_s = next_ptr_s;
        end else begin
            rr_start_s = ptr_r;
        end
    end

    // Grant index for the current request in the currently requested mode.
    always_comb begin
        sel_idx_s = {IWIDTH{1'b0}};
        case (mode)
            MODE_LSB: sel_idx_s = sel_lsb(req_s);
            MODE_MSB: sel_idx_s = sel_msb(req_s);
            MODE_RR:  sel_idx_s = sel_rr(req_s, rr_start_s);
            default:  sel_idx_s = sel_lsb(req_s);
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Result register: load a fresh result, drop valid on a bare accept,
    // otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r   <= {IWIDTH{1'b0}};
            onehot_r <= {DWIDTH{1'b0}};
            cnt_r    <= {CWIDTH{1'b0}};
            valid_r  <= 1'b0;
            mode_q_r <= MODE_LSB;
        end else if (load_s) begin
            mode_q_r <= mode;
            if (req_any_s) begin
                dout_r   <= sel_idx_s;
                onehot_r <= to_onehot(sel_idx_s);
                cnt_r    <= popcount(req_s);
                valid_r  <= 1'b1;
            end else begin
                dout_r   <= {IWIDTH{1'b0}};
                onehot_r <= {DWIDTH{1'b0}};
                cnt_r    <= {CWIDTH{1'b0}};
                valid_r  <= 1'b0;
            end
        end else if (accept_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Round-robin pointer: moves past the granted index on each
    // round-robin accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {IWIDTH{1'b0}};
        end else if (rr_adv_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign dout        = dout_r;
    assign dout_onehot = onehot_r;
    assign dout_cnt    = cnt_r;
    assign dout_v      = valid_r;

endmodule

// File: tb/tb_pri_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pri_arbiter
//   Directed, self-checking bench for pri_arbiter (DWIDTH = 8). A table of
//   single-cycle vectors covers the combinational selection and the
//   load/accept/hold rules. Hand-written sequences cover round-robin
//   rotation, backpressure and reset during a held result.
// -----------------------------------------------------------------------------
module tb_pri_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [7:0] din_v;
    logic       enable;
    logic [1:0] mode;
    logic [2:0] dout;
    logic [7:0] dout_onehot;
    logic [3:0] dout_cnt;
    logic       dout_v;
    logic       dout_rdy;

    int checks = 0;
    int errors = 0;

    pri_arbiter #(.DWIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_v       (din_v),
        .enable      (enable),
        .mode        (mode),
        .dout        (dout),
        .dout_onehot (dout_onehot),
        .dout_cnt    (dout_cnt),
        .dout_v      (dout_v),
        .dout_rdy    (dout_rdy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] din;
        logic [7:0] din_v;
        logic [1:0] mode;
        logic       enable;
        logic       rdy;
        logic       exp_v;
        logic [2:0] exp_dout;
        logic [7:0] exp_oh;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs [0:13];

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] d,
                             input logic [7:0] oh, input logic [3:0] cnt);
        check($sformatf("%s dout_v", tag),      32'(dout_v),      32'(v));
        check($sformatf("%s dout", tag),        32'(dout),        32'(d));
        check($sformatf("%s dout_onehot", tag), 32'(dout_onehot), 32'(oh));
        check($sformatf("%s dout_cnt", tag),    32'(dout_cnt),    32'(cnt));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    initial begin
        //                din     din_v   mode  en    rdy   v     dout  onehot  cnt
        vecs[0]  = '{8'h00, 8'hFF, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0}; // empty request
        vecs[1]  = '{8'hA4, 8'hFF, 2'd0, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04, 4'd3}; // LSB-first
        vecs[2]  = '{8'hA4, 8'hFF, 2'd1, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 4'd3}; // MSB-first
        vecs[3]  = '{8'hFF, 8'h0F, 2'd1, 1'b1, 1'b1, 1'b1, 3'd3, 8'h08, 4'd4}; // masked
        vecs[4]  = '{8'hFF, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0}; // fully masked
        vecs[5]  = '{8'h40, 8'hFF, 2'd0, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40, 4'd1}; // single, LSB
        vecs[6]  = '{8'h40, 8'hFF, 2'd1, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40, 4'd1}; // single, MSB
        vecs[7]  = '{8'hA4, 8'hFF, 2'd3, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04, 4'd3}; // mode 3 = LSB
        vecs[8]  = '{8'hFF, 8'hFF, 2'd0, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 4'd8}; // full count
        vecs[9]  = '{8'h01, 8'hFF, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 4'd8}; // accept, no load
        vecs[10] = '{8'h01, 8'hFF, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 4'd8}; // idle hold
        vecs[11] = '{8'h80, 8'hFF, 2'd2, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 4'd1}; // single, RR
        vecs[12] = '{8'h80, 8'hFF, 2'd2, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 4'd1}; // RR wrap from 7
        vecs[13] = '{8'h81, 8'hFF, 2'd1, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80, 4'd2}; // back to MSB

        din      = 8'h00;
        din_v    = 8'hFF;
        enable   = 1'b0;
        mode     = 2'd0;
        dout_rdy = 1'b1;

        // Reset state
        do_reset(10);
        check_out("reset", 1'b0, 3'd0, 8'h00, 4'd0);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            din      = vecs[i].din;
            din_v    = vecs[i].din_v;
            mode     = vecs[i].mode;
            enable   = vecs[i].enable;
            dout_rdy = vecs[i].rdy;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_dout,
                      vecs[i].exp_oh, vecs[i].exp_cnt);
        end

        // Round-robin rotation with all requesters and back-to-back accepts
        do_reset(1);
        mode     = 2'd2;
        din      = 8'hFF;
        din_v    = 8'hFF;
        enable   = 1'b1;
        dout_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_out($sformatf("rr_all%0d", i), 1'b1, 3'(i % 8),
                      8'h01 << (i % 8), 4'd8);
        end
        din = 8'h11;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("rr_two%0d", i), 1'b1, (i % 2 == 0) ? 3'd4 : 3'd0,
                      (i % 2 == 0) ? 8'h10 : 8'h01, 4'd2);
        end

        // Backpressure: drain, then load dout=2 and hold it under rdy=0
        enable = 1'b0;
        step();
        check("bp_drain dout_v", 32'(dout_v), 32'd0);
        mode     = 2'd0;
        din      = 8'hA4;
        enable   = 1'b1;
        dout_rdy = 1'b0;
        step();
        check_out("bp_load", 1'b1, 3'd2, 8'h04, 4'd3);
        din  = 8'h80;
        mode = 2'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("bp_hold%0d", i), 1'b1, 3'd2, 8'h04, 4'd3);
        end
        dout_rdy = 1'b1;
        step();
        check_out("bp_release", 1'b1, 3'd7, 8'h80, 4'd1);
        dout_rdy = 1'b0;
        step();
        check_out("bp_after", 1'b1, 3'd7, 8'h80, 4'd1);

        // Reset while a round-robin result is held with ptr=5
        do_reset(1);
        mode     = 2'd2;
        din      = 8'hFF;
        din_v    = 8'hFF;
        enable   = 1'b1;
        dout_rdy = 1'b1;
        repeat (6) step();
        check_out("mid_run", 1'b1, 3'd5, 8'h20, 4'd8);
        dout_rdy = 1'b0;
        step();
        check_out("mid_hold", 1'b1, 3'd5, 8'h20, 4'd8);
        rst = 1'b1;
        step();
        check_out("mid_reset", 1'b0, 3'd0, 8'h00, 4'd0);
        rst      = 1'b0;
        dout_rdy = 1'b1;
        step();
        check_out("post_reset", 1'b1, 3'd0, 8'h01, 4'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
